cnu_min_serial: RTL and testbench
=================================

CNU_MIN_SERIAL -- requirements
Module: cnu_min_serial

Interface
REQ-001 Parameter QUAN_SIZE, default 4, magnitude width of one check-node input message.
REQ-002 Parameter MAX_DEGREE, default 10, largest check-node degree supported.
REQ-003 Parameter IDX_W, default $clog2(MAX_DEGREE), width of the minimum-index output.
REQ-004 Port clk  in  1  system clock; the block uses this single clock.
REQ-005 Port rstn  in  1  reset, asynchronous, active-low.
REQ-006 Port degree_cfg  in  IDX_W+1  check-node degree of the next frame.
REQ-007 Port in_valid  in  1  an input message beat is offered.
REQ-008 Port in_ready  out  1  the block accepts the offered beat.
REQ-009 Port in_mag  in  QUAN_SIZE  unsigned message magnitude.
REQ-010 Port in_sign  in  1  message sign bit (1 = negative).
REQ-011 Port out_valid  out  1  the frame result is presented.
REQ-012 Port out_ready  in  1  the consumer takes the result.
REQ-013 Port min1  out  QUAN_SIZE  smallest magnitude in the frame.
REQ-014 Port min2  out  QUAN_SIZE  second-smallest magnitude in the frame.
REQ-015 Port min_index  out  IDX_W  beat position (0-based) of min1.
REQ-016 Port sign_prod  out  1  XOR of all in_sign bits in the frame.

Function
REQ-017 A beat SHALL transfer only on a clock edge where in_valid and in_ready are both 1; a result SHALL transfer only on a clock edge where out_valid and out_ready are both 1.
REQ-018 FSM states: IDLE, ACCUM and DONE. in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE. out_valid SHALL be 1 only in DONE.
REQ-019 IDLE, first beat accepted: latch the effective degree D from degree_cfg and set beat count = 1.
  - min1 = in_mag, min2 = all-ones, min_index = 0, sign_prod = in_sign.
  - Next state ACCUM, or DONE if D = 1.
REQ-020 Effective degree D SHALL be degree_cfg clamped to the range 1..MAX_DEGREE; a degree_cfg of 0 SHALL be treated as 1.
REQ-021 ACCUM, beat k accepted, with m = in_mag:
  - if m < min1: min2 = min1, min1 = m, min_index = k.
  - else if m < min2: min2 = m.
  - sign_prod ^= in_sign.
REQ-022 Ties SHALL keep the earliest index: m equal to min1 updates min2 only.
REQ-023 After the D-th beat is accepted, the state SHALL move to DONE. out_valid SHALL rise on the edge that accepts the last beat, giving 1-cycle latency.
REQ-024 DONE SHALL hold all result outputs stable until the result transfers. After the transfer the state SHALL return to IDLE, and the next frame's first beat can be accepted on the following cycle.
REQ-025 If D = 1, min2 SHALL read all-ones (saturated) at the output.
REQ-026 degree_cfg changes after the first beat of a frame SHALL have no effect on that frame.
REQ-027 The beat counter SHALL never exceed D−1 and SHALL never wrap within a frame.

Reset
REQ-028 rstn low SHALL immediately force the following, at any point including mid-frame:
  - state = IDLE, out_valid = 0.
  - min1 = 0, min2 = 0, min_index = 0, sign_prod = 0, beat count = 0.
  - any partial frame is discarded.
REQ-029 in_ready SHALL be 0 while rstn is low and SHALL be 1 from the first clock edge after rstn is released.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding and the default QUAN_SIZE / MAX_DEGREE constants.
REQ-031 The compare-and-update step SHALL be one sub-module, min2_update (combinational).
  - Inputs: current min1, min2, min_index, plus the new magnitude and beat index.
  - Outputs: next min1, min2, min_index.
  - It is reused by future parallel CNU variants.

Verification
REQ-032 QUAN_SIZE=4, D=8, magnitudes 7,3,9,3,12,5,1,6, signs 1,0,0,1,0,0,1,0 -> min1=1, min2=3, min_index=6, sign_prod=1.
REQ-033 D=6, magnitudes 4,4,4,4,4,4 -> min1=4, min2=4, min_index=0 (tie rule).
REQ-034 D=1, magnitude 5 -> min1=5, min2=15, min_index=0. out_valid rises one cycle after the beat.
REQ-035 D=10, out_ready held low 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. The transfer happens when out_ready=1, and a new frame is accepted the next cycle.
REQ-036 rstn pulsed low after 3 beats of a D=8 frame -> out_valid=0 and outputs zero. A fresh D=6 frame afterwards gives a correct result, unaffected by the partial frame.

Source files
------------

// File: rtl/cnu_min_serial_pkg.sv
// -----------------------------------------------------------------------------
// cnu_min_serial_pkg
// Shared definitions for the serial min-sum check-node unit:
//   - default message magnitude width and maximum check-node degree
//   - FSM state encoding used by cnu_min_serial
// -----------------------------------------------------------------------------
package cnu_min_serial_pkg;

    localparam int DEF_QUAN_SIZE  = 4;
    localparam int DEF_MAX_DEGREE = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first beat of a frame
        ACCUM = 2'd1,   // folding beats 1..D-1 into the running minima
        DONE  = 2'd2    // result presented, waiting for the consumer
    } state_t;

endpackage

// File: rtl/cnu_min_serial_if.sv
// -----------------------------------------------------------------------------
// cnu_min_serial_if
// Message-in / result-out bundle of the serial check-node unit.
//   degree_cfg          degree of the next frame (sampled on its first beat)
//   in_valid/in_ready   input beat handshake, payload in_mag + in_sign
//   out_valid/out_ready result handshake, payload min1, min2, min_index,
//                       sign_prod
// master: message producer / result consumer.  slave: the CNU.
// -----------------------------------------------------------------------------
interface cnu_min_serial_if
    import cnu_min_serial_pkg::*;
#(
    parameter int QUAN_SIZE  = DEF_QUAN_SIZE,
    parameter int MAX_DEGREE = DEF_MAX_DEGREE,
    parameter int IDX_W      = $clog2(MAX_DEGREE)
);

    logic [IDX_W:0]     degree_cfg;
    logic               in_valid;
    logic               in_ready;
    logic [QUAN_SIZE-1:0] in_mag;
    logic               in_sign;
    logic               out_valid;
    logic               out_ready;
    logic [QUAN_SIZE-1:0] min1;
    logic [QUAN_SIZE-1:0] min2;
    logic [IDX_W-1:0]   min_index;
    logic               sign_prod;

    modport master (
        output degree_cfg, in_valid, in_mag, in_sign, out_ready,
        input  in_ready, out_valid, min1, min2, min_index, sign_prod
    );

    modport slave (
        input  degree_cfg, in_valid, in_mag, in_sign, out_ready,
        output in_ready, out_valid, min1, min2, min_index, sign_prod
    );

endinterface

// File: rtl/cnu_min_serial_min2_update.sv
// -----------------------------------------------------------------------------
// min2_update
// Combinational compare-and-update of a (min1, min2, min_index) triple with
// one new magnitude.
//   cur_min1/cur_min2/cur_index  running state
//   new_mag/new_index            incoming magnitude and its beat position
//   nxt_min1/nxt_min2/nxt_index  updated state
// A magnitude equal to min1 only lands in min2, so the earliest index wins.
// -----------------------------------------------------------------------------
module min2_update
    import cnu_min_serial_pkg::*;
#(
    parameter int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter int IDX_W     = $clog2(DEF_MAX_DEGREE)
) (
    input  logic [QUAN_SIZE-1:0] cur_min1,
    input  logic [QUAN_SIZE-1:0] cur_min2,
    input  logic [IDX_W-1:0]     cur_index,
    input  logic [QUAN_SIZE-1:0] new_mag,
    input  logic [IDX_W-1:0]     new_index,
    output logic [QUAN_SIZE-1:0] nxt_min1,
    output logic [QUAN_SIZE-1:0] nxt_min2,
    output logic [IDX_W-1:0]     nxt_index
);

    always_comb begin
        nxt_min1  = cur_min1;
        nxt_min2  = cur_min2;
        nxt_index = cur_index;
        if (new_mag < cur_min1) begin
            nxt_min2  = cur_min1;
            nxt_min1  = new_mag;
            nxt_index = new_index;
        end else if (new_mag < cur_min2) begin
            nxt_min2  = new_mag;
        end
    end

endmodule

// File: rtl/cnu_min_serial.sv
// -----------------------------------------------------------------------------
// cnu_min_serial
// Serial min-sum check-node unit: accepts D message beats (one per cycle at
// most), tracks the two smallest magnitudes, the position of the smallest and
// the XOR of all signs, then presents the result until it is taken.
//   clk   single clock
//   rstn  asynchronous active-low reset
//   bus   cnu_min_serial_if.slave (input beats, degree config, result)
// All handshake and result outputs come straight from registers.
// -----------------------------------------------------------------------------
module cnu_min_serial
    import cnu_min_serial_pkg::*;
#(
    parameter int QUAN_SIZE  = DEF_QUAN_SIZE,
    parameter int MAX_DEGREE = DEF_MAX_DEGREE,
    parameter int IDX_W      = $clog2(MAX_DEGREE)
) (
    input  logic            clk,
    input  logic            rstn,
    cnu_min_serial_if.slave bus
);

    localparam logic [IDX_W:0] DEG_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] DEG_MAX = (IDX_W+1)'(MAX_DEGREE);

    state_t               state_reg;
    logic [IDX_W:0]       deg_reg;
    logic [IDX_W-1:0]     count_reg;
    logic [QUAN_SIZE-1:0] min1_reg;
    logic [QUAN_SIZE-1:0] min2_reg;
    logic [IDX_W-1:0]     index_reg;
    logic                 sign_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;

    logic [IDX_W:0]       deg_clamped;
    logic                 beat_fire;
    logic                 out_fire;
    logic                 last_beat;
    logic [QUAN_SIZE-1:0] min1_next;
    logic [QUAN_SIZE-1:0] min2_next;
    logic [IDX_W-1:0]     index_next;

    // Effective degree: 0 behaves as 1, anything above MAX_DEGREE saturates.
    always_comb begin
        deg_clamped = bus.degree_cfg;
        if (bus.degree_cfg == '0)
            deg_clamped = DEG_ONE;
        else if (bus.degree_cfg > DEG_MAX)
            deg_clamped = DEG_MAX;
    end

    assign beat_fire = bus.in_valid && in_ready_reg;
    assign out_fire  = out_valid_reg && bus.out_ready;
    // count_reg holds the index of the beat about to be accepted.
    assign last_beat = ({1'b0, count_reg} == (deg_reg - DEG_ONE));

    min2_update #(
        .QUAN_SIZE (QUAN_SIZE),
        .IDX_W     (IDX_W)
    ) u_min2_update (
        .cur_min1  (min1_reg),
        .cur_min2  (min2_reg),
        .cur_index (index_reg),
        .new_mag   (bus.in_mag),
        .new_index (count_reg),
        .nxt_min1  (min1_next),
        .nxt_min2  (min2_next),
        .nxt_index (index_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            deg_reg       <= '0;
            count_reg     <= '0;
            min1_reg      <= '0;
            min2_reg      <= '0;
            index_reg     <= '0;
            sign_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (beat_fire) begin
                        deg_reg   <= deg_clamped;
                        min1_reg  <= bus.in_mag;
                        min2_reg  <= '1;
                        index_reg <= '0;
                        sign_reg  <= bus.in_sign;
                        if (deg_clamped == DEG_ONE) begin
                            // Single-beat frame: counter stays at D-1 = 0.
                            count_reg     <= '0;
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            count_reg <= IDX_W'(1);
                            state_reg <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    if (beat_fire) begin
                        min1_reg  <= min1_next;
                        min2_reg  <= min2_next;
                        index_reg <= index_next;
                        sign_reg  <= sign_reg ^ bus.in_sign;
                        if (last_beat) begin
                            count_reg     <= '0;
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + IDX_W'(1);
                        end
                    end
                end

                DONE: begin
                    if (out_fire) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    count_reg     <= '0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.min1      = min1_reg;
    assign bus.min2      = min2_reg;
    assign bus.min_index = index_reg;
    assign bus.sign_prod = sign_reg;

endmodule

// File: tb/tb_cnu_min_serial.sv
// -----------------------------------------------------------------------------
// tb_cnu_min_serial
// Directed bench for cnu_min_serial: fixed frames with hand-computed minima,
// degree clamping, back-pressure on the result, and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_cnu_min_serial;
    import cnu_min_serial_pkg::*;

    localparam int Q    = 4;
    localparam int MAXD = 10;
    localparam int IW   = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int waited;

    always #5 clk = ~clk;

    cnu_min_serial_if #(.QUAN_SIZE(Q), .MAX_DEGREE(MAXD), .IDX_W(IW)) bus ();

    cnu_min_serial #(
        .QUAN_SIZE  (Q),
        .MAX_DEGREE (MAXD),
        .IDX_W      (IW)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [3:0] f1_mag [8]  = '{4'd7, 4'd3, 4'd9, 4'd3, 4'd12, 4'd5, 4'd1, 4'd6};
    logic       f1_sgn [8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] f5_mag [10] = '{4'd8, 4'd6, 4'd11, 4'd2, 4'd14, 4'd2, 4'd7, 4'd13, 4'd9, 4'd3};
    logic       f5_sgn [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] f8_mag [6]  = '{4'd9, 4'd8, 4'd7, 4'd10, 4'd11, 4'd12};
    logic       f8_sgn [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input int m1, input int m2,
                                input int idx, input int sp);
        check({tag, "_min1"},      32'(bus.min1),      32'(m1));
        check({tag, "_min2"},      32'(bus.min2),      32'(m2));
        check({tag, "_min_index"}, 32'(bus.min_index), 32'(idx));
        check({tag, "_sign_prod"}, 32'(bus.sign_prod), 32'(sp));
    endtask

    // Offer one beat and return once it has been accepted (inputs released
    // 1 time unit after the accepting edge). waited = cycles spent stalled.
    task automatic send_beat(input logic [3:0] m, input logic s, output int w);
        bus.in_mag   = m;
        bus.in_sign  = s;
        bus.in_valid = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_dropped"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"},     32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.degree_cfg = '0;
        bus.in_valid   = 1'b0;
        bus.in_mag     = '0;
        bus.in_sign    = 1'b0;
        bus.out_ready  = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_result("rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_in_ready", 32'(bus.in_ready), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // ---------------- frame 1: D=8, degree_cfg changed mid-frame ----------------
        bus.degree_cfg = 5'd8;
        for (int i = 0; i < 8; i++) begin
            send_beat(f1_mag[i], f1_sgn[i], waited);
            if (i == 0) bus.degree_cfg = 5'd3;
            if (i == 6) check("f1_no_early_valid", 32'(bus.out_valid), 32'd0);
        end
        check("f1_out_valid",  32'(bus.out_valid), 32'd1);
        check("f1_in_ready_0", 32'(bus.in_ready),  32'd0);
        check_result("f1", 1, 3, 6, 1);
        take_result("f1");

        // ---------------- frame 2: D=6, all ties ----------------
        bus.degree_cfg = 5'd6;
        for (int i = 0; i < 6; i++) send_beat(4'd4, 1'b0, waited);
        check("f2_out_valid", 32'(bus.out_valid), 32'd1);
        check_result("f2", 4, 4, 0, 0);
        take_result("f2");

        // ---------------- frame 3: D=1 ----------------
        bus.degree_cfg = 5'd1;
        send_beat(4'd5, 1'b1, waited);
        check("f3_out_valid", 32'(bus.out_valid), 32'd1);
        check_result("f3", 5, 15, 0, 1);
        take_result("f3");

        // ---------------- frame 4: degree_cfg=0 behaves as 1 ----------------
        bus.degree_cfg = 5'd0;
        send_beat(4'd9, 1'b0, waited);
        check("f4_out_valid", 32'(bus.out_valid), 32'd1);
        check_result("f4", 9, 15, 0, 0);
        take_result("f4");

        // ---------------- frame 5: degree_cfg=15 clamps to 10, back-pressure ----------------
        bus.degree_cfg = 5'd15;
        for (int i = 0; i < 10; i++) begin
            send_beat(f5_mag[i], f5_sgn[i], waited);
            if (i == 8) check("f5_no_early_valid", 32'(bus.out_valid), 32'd0);
        end
        check("f5_out_valid", 32'(bus.out_valid), 32'd1);
        check_result("f5", 2, 2, 3, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("f5_hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("f5_hold_in_ready",  32'(bus.in_ready),  32'd0);
            check_result("f5_hold", 2, 2, 3, 1);
        end
        take_result("f5");

        // ---------------- frame 6: accepted on the cycle right after the transfer ----------------
        bus.degree_cfg = 5'd1;
        send_beat(4'd0, 1'b0, waited);
        check("f6_no_stall",  32'(waited),        32'd0);
        check("f6_out_valid", 32'(bus.out_valid), 32'd1);
        check_result("f6", 0, 15, 0, 0);
        take_result("f6");

        // ---------------- frame 7: reset after 3 of 8 beats ----------------
        bus.degree_cfg = 5'd8;
        send_beat(4'd6, 1'b1, waited);
        send_beat(4'd5, 1'b0, waited);
        send_beat(4'd4, 1'b0, waited);
        #1;
        rstn = 1'b0;
        #2;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check_result("mid_rst", 0, 0, 0, 0);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rel_out_valid", 32'(bus.out_valid), 32'd0);

        // ---------------- frame 8: fresh D=6 frame after the reset ----------------
        bus.degree_cfg = 5'd6;
        for (int i = 0; i < 6; i++) begin
            send_beat(f8_mag[i], f8_sgn[i], waited);
            if (i == 4) check("f8_no_early_valid", 32'(bus.out_valid), 32'd0);
        end
        check("f8_out_valid", 32'(bus.out_valid), 32'd1);
        check_result("f8", 7, 8, 2, 1);
        take_result("f8");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
